// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall/flush/forward control with data-memory wait FSM.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [RA_W-1:0]   RsD,
  input  logic [RA_W-1:0]   RtD,
  input  logic [RA_W-1:0]   RsE,
  input  logic [RA_W-1:0]   RtE,
  input  logic [RA_W-1:0]   WriteRegE,
  input  logic [RA_W-1:0]   WriteRegM,
  input  logic [RA_W-1:0]   WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t        state, state_next;
  logic [TW-1:0] wait_cnt, wait_cnt_next;
  logic          lwstall, brstall, memstall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE: begin
        wait_cnt_next = '0;
        if (MemReqM && !MemReadyM) state_next = S_WAIT;
      end
      S_WAIT: begin
        // A ready response always wins, even on the cycle the timeout would hit.
        if (MemReadyM) begin
          state_next    = S_IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
          if (wait_cnt_next == TW'(MEM_TIMEOUT)) state_next = S_ERR;
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    lwstall  = MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
    brstall  = BranchD &&
               ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
    memstall = (state == S_ERR) || (MemReqM && !MemReadyM);

    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    MemErr    = 1'b0;
    if (!rst) begin
      StallF = lwstall || brstall || memstall;
      StallD = StallF;
      StallE = memstall;
      StallM = memstall;
      FlushE = (lwstall || brstall) && !memstall;
      FlushD = PCSrcD && !StallD;
      if (RegWriteM && hit(WriteRegM, RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && hit(WriteRegW, RsE)) ForwardAE = 2'b01;
      if (RegWriteM && hit(WriteRegM, RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && hit(WriteRegW, RtE)) ForwardBE = 2'b01;
      ForwardAD = RegWriteM && hit(WriteRegM, RsD);
      ForwardBD = RegWriteM && hit(WriteRegM, RtD);
      MemErr    = (state == S_ERR);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1))               StallCnt <= StallCnt + 1'b1;
      if ((FlushD || FlushE) && (FlushCnt != '1))   FlushCnt <= FlushCnt + 1'b1;
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
